data_mem_ctrl: RTL

//   Parametrised data memory for the pipelined CPU's MEM stage, replacing the fixed 1KB word-only memory.

---
 rtl/data_mem_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory for the MEM stage with wait states and a valid/ready handshake.
// Optional build macro MISALIGN_ERR_EN: misaligned half/word accesses error instead of being force-aligned.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        accept, enter_resp;

    logic        lat_we, lat_uns;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr, lat_wdata;

    logic        op_we, op_uns;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;

    logic [2:0]  op_bytes;
    logic [32:0] last_byte;
    logic        misalign, op_err;
    logic [AW-1:0] base;
    logic [AW-1:0] byte_idx [4];
    logic [31:0] raw, ext;

    logic [7:0]  mem [DEPTH_BYTES];
    logic [31:0] load_q;
    logic        err_q;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);

    // With zero wait states the commit edge is the accept edge, so the live request must be used there.
    always_comb begin
        op_we    = lat_we;
        op_uns   = lat_uns;
        op_size  = lat_size;
        op_addr  = lat_addr;
        op_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            op_we    = req_we;
            op_uns   = req_unsigned;
            op_size  = req_size;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
    end

    assign enter_resp = !rst && (((state == ST_IDLE) && accept && (WAIT_STATES == 0)) ||
                                 ((state == ST_WAIT) && (cnt == 4'd1)));

    // Range is judged on the requested address, so a request straddling the top errors even if alignment would pull it back.
    always_comb begin
        case (op_size)
            2'b00:   op_bytes = 3'd1;
            2'b01:   op_bytes = 3'd2;
            default: op_bytes = 3'd4;
        endcase
        last_byte = {1'b0, op_addr} + {30'b0, op_bytes} - 33'd1;
`ifdef MISALIGN_ERR_EN
        misalign = ((op_size == 2'b01) && op_addr[0]) ||
                   ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
        base     = op_addr[AW-1:0];
`else
        misalign = 1'b0;
        base     = op_addr[AW-1:0] & ~AW'(op_bytes - 3'd1);
`endif
        op_err = (op_size == 2'b11) || (last_byte >= 33'(DEPTH_BYTES)) || misalign;

        raw = '0;
        for (int k = 0; k < 4; k++) begin
            byte_idx[k]    = base + AW'(k);
            raw[8*k +: 8]  = mem[byte_idx[k]];
        end

        case (op_size)
            2'b00:   ext = op_uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   ext = op_uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 4'd1) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= WAIT_INIT;
            else if (state == ST_WAIT)
                cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
        if (enter_resp) begin
            load_q <= (op_we || op_err) ? 32'd0 : ext;
            err_q  <= op_err;
        end
    end

    // Storage has no reset: contents survive rst and only change on a committed store.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < op_bytes)
                    mem[byte_idx[k]] <= op_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != ST_RESP)) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_q;
            rsp_err   <= err_q;
        end
    end

endmodule
